// File: rtl/z_result_stage.sv
// Z result holding stage: captures the 64-bit ALU result, drains it as 1 or 2 valid/ready beats.
// Latency 1 (valid the cycle after capture); holds the beat while !wb_ready. Optional flags: Z_RESULT_FLAGS_EN.
module z_result_stage #(
  parameter int         HALF_W = 32,
  parameter logic [4:0] MUL_OP = 5'b01111,
  parameter logic [4:0] DIV_OP = 5'b10000
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                z_in,
  input  logic [2*HALF_W-1:0] alu_c,
  input  logic [4:0]          op_code,
  input  logic                wb_ready,
  output logic                wb_valid,
  output logic [HALF_W-1:0]   wb_data,
  output logic                wb_is_hi,
  output logic [HALF_W-1:0]   zlo_q,
  output logic [HALF_W-1:0]   zhi_q,
  output logic                busy,
  output logic                overrun,
  output logic                flag_zero,
  output logic                flag_neg
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [HALF_W-1:0]   r_zlo;
  logic [HALF_W-1:0]   r_zhi;
  logic [4:0]          r_op;
  logic                r_overrun;
  logic                w_two_beat;
  logic                w_final_hs;
  logic                w_accept;

  assign w_two_beat = (r_op == MUL_OP) || (r_op == DIV_OP);

  // The last beat of a result leaving frees the registers for a same-cycle capture.
  assign w_final_hs = ((r_state == LO) && !w_two_beat && wb_ready) ||
                      ((r_state == HI) && wb_ready);
  assign w_accept   = z_in && ((r_state == IDLE) || w_final_hs);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = LO;
      LO: begin
        if (wb_ready) begin
          if (w_two_beat)    w_next = HI;
          else if (w_accept) w_next = LO;
          else               w_next = IDLE;
        end
      end
      HI: begin
        if (wb_ready) w_next = w_accept ? LO : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= IDLE;
      r_zlo     <= '0;
      r_zhi     <= '0;
      r_op      <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_overrun <= z_in && !w_accept;
      if (w_accept) begin
        r_zlo <= alu_c[HALF_W-1:0];
        r_zhi <= alu_c[2*HALF_W-1:HALF_W];
        r_op  <= op_code;
      end
    end
  end

`ifdef Z_RESULT_FLAGS_EN
  logic r_flag_zero;
  logic r_flag_neg;
  logic w_cap_two;

  assign w_cap_two = (op_code == MUL_OP) || (op_code == DIV_OP);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_flag_zero <= 1'b0;
      r_flag_neg  <= 1'b0;
    end else if (w_accept) begin
      if (w_cap_two) begin
        r_flag_zero <= (alu_c == '0);
        r_flag_neg  <= alu_c[2*HALF_W-1];
      end else begin
        r_flag_zero <= (alu_c[HALF_W-1:0] == '0);
        r_flag_neg  <= alu_c[HALF_W-1];
      end
    end
  end

  assign flag_zero = r_flag_zero;
  assign flag_neg  = r_flag_neg;
`else
  assign flag_zero = 1'b0;
  assign flag_neg  = 1'b0;
`endif

  assign wb_valid = (r_state != IDLE);
  assign busy     = (r_state != IDLE);
  assign wb_is_hi = (r_state == HI);
  assign wb_data  = (r_state == LO) ? r_zlo :
                    (r_state == HI) ? r_zhi : '0;
  assign zlo_q    = r_zlo;
  assign zhi_q    = r_zhi;
  assign overrun  = r_overrun;

endmodule
